// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the IF-stage next-PC predictor.
// BTB fields are sized for RV32, so XLEN is expected to be at most PC_W_MAX.
package branch_predictor_pkg;

    localparam int MODE_STATIC  = 0;
    localparam int MODE_BIMODAL = 1;
    localparam int MODE_GSHARE  = 2;

    localparam logic [1:0] PHT_INIT = 2'b01;

    localparam int PC_W_MAX = 32;

    typedef struct packed {
        logic                valid;
        logic                uncond;
        logic [PC_W_MAX-1:0] tag;
        logic [PC_W_MAX-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating counter (one per PHT entry).
module sat_counter2 (
    input  logic [1:0] count,
    input  logic       inc,
    output logic [1:0] next_count
);

    always_comb begin
        next_count = count;
        if (inc) begin
            if (count != 2'b11) begin
                next_count = count + 2'b01;
            end
        end else if (count != 2'b00) begin
            next_count = count - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor: tagged BTB, 2-bit PHT, non-speculative GHR and perf counters.
// Lookup is combinational on the current tables; training from EX lands on the clock edge.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 32,
    parameter int GHR_BITS    = 5,
    parameter int MODE        = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     pred_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_next_pc,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_is_cond,
    input  logic                upd_is_jump,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict,
    output logic [31:0]         perf_cf_cnt,
    output logic [31:0]         perf_mispred_cnt
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    function automatic logic [PC_W_MAX-1:0] tag_of(input logic [XLEN-1:0] pc);
        return PC_W_MAX'(pc >> (IDX + 2));
    endfunction

    function automatic logic [IDX-1:0] pht_index(input logic [IDX-1:0] idx,
                                                 input logic [GHR_BITS-1:0] hist);
        return (MODE == MODE_GSHARE) ? (idx ^ IDX'(hist)) : idx;
    endfunction

    btb_entry_t          btb      [BTB_ENTRIES];
    logic [1:0]          pht      [BTB_ENTRIES];
    logic [1:0]          pht_next [BTB_ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_shifted;
    logic [31:0]         cf_cnt;
    logic [31:0]         mis_cnt;

    logic [IDX-1:0] look_idx;
    logic [IDX-1:0] look_pidx;
    logic [IDX-1:0] upd_idx;
    logic [IDX-1:0] upd_pidx;
    btb_entry_t     look_entry;
    btb_entry_t     btb_wdata;
    logic           look_hit;
    logic           btb_we;
    logic           pht_we;
    logic           cf_inc;
    logic           mis_inc;
    logic           unused_pc_bits;

    assign look_idx       = pred_pc[IDX+1:2];
    assign look_pidx      = pht_index(look_idx, ghr);
    assign upd_idx        = upd_pc[IDX+1:2];
    assign upd_pidx       = pht_index(upd_idx, upd_ghr);
    assign unused_pc_bits = ^upd_pc[1:0];

    // A cond+jump encoding is treated as a jump, so only pure conditionals train PHT/GHR
    assign btb_we  = upd_valid && (upd_is_cond || upd_is_jump) && upd_taken;
    assign pht_we  = upd_valid && upd_is_cond && !upd_is_jump;
    assign cf_inc  = upd_valid && (upd_is_cond || upd_is_jump);
    assign mis_inc = upd_valid && upd_mispredict;

    always_comb begin
        look_entry   = btb[look_idx];
        look_hit     = look_entry.valid && (look_entry.tag == tag_of(pred_pc));
        pred_taken   = (MODE != MODE_STATIC) && look_hit &&
                       (look_entry.uncond || pht[look_pidx][1]);
        pred_next_pc = pred_taken ? XLEN'(look_entry.target) : pred_pc + XLEN'(4);
    end

    always_comb begin
        btb_wdata        = '0;
        btb_wdata.valid  = 1'b1;
        btb_wdata.uncond = upd_is_jump;
        btb_wdata.tag    = tag_of(upd_pc);
        btb_wdata.target = PC_W_MAX'(upd_target);
    end

    generate
        if (GHR_BITS > 1) begin : g_ghr_wide
            assign ghr_shifted = {ghr[GHR_BITS-2:0], upd_taken};
        end else begin : g_ghr_one
            assign ghr_shifted = upd_taken;
        end

        for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_pht_ctr
            sat_counter2 u_ctr (
                .count      (pht[g]),
                .inc        (upd_taken),
                .next_count (pht_next[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i] <= '0;
            end
        end else if (btb_we) begin
            btb[upd_idx] <= btb_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                pht[i] <= PHT_INIT;
            end
        end else begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                if (pht_we && (upd_pidx == IDX'(i))) begin
                    pht[i] <= pht_next[i];
                end
            end
        end
    end

    // History is shifted only at resolution, so it never needs repair after a flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr     <= '0;
            cf_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (pht_we) begin
                ghr <= ghr_shifted;
            end
            if (cf_inc && (cf_cnt != '1)) begin
                cf_cnt <= cf_cnt + 32'd1;
            end
            if (mis_inc && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + 32'd1;
            end
        end
    end

    assign pred_ghr         = ghr;
    assign perf_cf_cnt      = cf_cnt;
    assign perf_mispred_cnt = mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: three predictors (static, bimodal, gshare) share stimulus and are
// compared every cycle against a behavioural model of the tables.
module tb_branch_predictor;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [4:0]  upd_ghr;
    logic        upd_mispredict;

    logic        taken_s, taken_b, taken_g;
    logic [31:0] next_s, next_b, next_g;
    logic [4:0]  ghr_s, ghr_b, ghr_g;
    logic [31:0] cf_s, cf_b, cf_g;
    logic [31:0] mis_s, mis_b, mis_g;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .BTB_ENTRIES(N), .GHR_BITS(5), .MODE(0)) u_static (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(taken_s),
        .pred_next_pc(next_s), .pred_ghr(ghr_s), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_is_cond(upd_is_cond), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
        .perf_cf_cnt(cf_s), .perf_mispred_cnt(mis_s)
    );

    branch_predictor #(.XLEN(32), .BTB_ENTRIES(N), .GHR_BITS(5), .MODE(1)) u_bimodal (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(taken_b),
        .pred_next_pc(next_b), .pred_ghr(ghr_b), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_is_cond(upd_is_cond), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
        .perf_cf_cnt(cf_b), .perf_mispred_cnt(mis_b)
    );

    branch_predictor #(.XLEN(32), .BTB_ENTRIES(N), .GHR_BITS(5), .MODE(2)) u_gshare (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(taken_g),
        .pred_next_pc(next_g), .pred_ghr(ghr_g), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_is_cond(upd_is_cond), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
        .perf_cf_cnt(cf_g), .perf_mispred_cnt(mis_g)
    );

    typedef struct packed {
        logic [2:0]  taken;
        logic [95:0] next;
        logic [4:0]  ghr;
        logic [31:0] cf;
        logic [31:0] mis;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step  = 0;
    logic g_pred;
    logic obs_g_taken;

    logic        m_valid [N];
    logic        m_unc   [N];
    logic [24:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    logic [1:0]  m_pht_b [N];
    logic [1:0]  m_pht_g [N];
    logic [4:0]  m_ghr;
    logic [31:0] m_cf;
    logic [31:0] m_mis;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] bump(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [32:0] modelPredict(input int mode, input logic [31:0] pc);
        logic [4:0] idx;
        logic [4:0] pidx;
        logic [1:0] ctr;
        logic       hit;
        logic       tk;
        idx  = pc[6:2];
        hit  = m_valid[idx] && (m_tag[idx] == pc[31:7]);
        pidx = (mode == 2) ? (idx ^ m_ghr) : idx;
        ctr  = (mode == 2) ? m_pht_g[pidx] : m_pht_b[pidx];
        tk   = (mode != 0) && hit && (m_unc[idx] || ctr[1]);
        return {tk, tk ? m_tgt[idx] : pc + 32'd4};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_unc[i]   = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_pht_b[i] = 2'b01;
            m_pht_g[i] = 2'b01;
        end
        m_ghr = '0;
        m_cf  = '0;
        m_mis = '0;
    endtask

    task automatic modelUpdate();
        logic [4:0] idx;
        if (!upd_valid) return;
        idx = upd_pc[6:2];
        if ((upd_is_cond || upd_is_jump) && m_cf != 32'hFFFF_FFFF) m_cf++;
        if (upd_mispredict && m_mis != 32'hFFFF_FFFF) m_mis++;
        if ((upd_is_cond || upd_is_jump) && upd_taken) begin
            m_valid[idx] = 1'b1;
            m_unc[idx]   = upd_is_jump;
            m_tag[idx]   = upd_pc[31:7];
            m_tgt[idx]   = upd_target;
        end
        if (upd_is_cond && !upd_is_jump) begin
            m_pht_b[idx]           = bump(m_pht_b[idx], upd_taken);
            m_pht_g[idx ^ upd_ghr] = bump(m_pht_g[idx ^ upd_ghr], upd_taken);
            m_ghr                  = {m_ghr[3:0], upd_taken};
        end
    endtask

    task automatic sampleOutputs();
        exp_t e;
        if (q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL sb.empty: got no expectation, expected one queued");
            return;
        end
        e = q.pop_front();
        step++;
        obs_g_taken = taken_g;
        checkOutput($sformatf("s%0d.taken_s", step), taken_s, e.taken[0]);
        checkOutput($sformatf("s%0d.taken_b", step), taken_b, e.taken[1]);
        checkOutput($sformatf("s%0d.taken_g", step), taken_g, e.taken[2]);
        checkOutput($sformatf("s%0d.next_s", step), next_s, e.next[31:0]);
        checkOutput($sformatf("s%0d.next_b", step), next_b, e.next[63:32]);
        checkOutput($sformatf("s%0d.next_g", step), next_g, e.next[95:64]);
        checkOutput($sformatf("s%0d.ghr_s", step), ghr_s, e.ghr);
        checkOutput($sformatf("s%0d.ghr_b", step), ghr_b, e.ghr);
        checkOutput($sformatf("s%0d.ghr_g", step), ghr_g, e.ghr);
        checkOutput($sformatf("s%0d.cf_s", step), cf_s, e.cf);
        checkOutput($sformatf("s%0d.cf_b", step), cf_b, e.cf);
        checkOutput($sformatf("s%0d.cf_g", step), cf_g, e.cf);
        checkOutput($sformatf("s%0d.mis_s", step), mis_s, e.mis);
        checkOutput($sformatf("s%0d.mis_b", step), mis_b, e.mis);
        checkOutput($sformatf("s%0d.mis_g", step), mis_g, e.mis);
    endtask

    // Called just after a rising edge; the update driven here commits on the next edge
    task automatic applyStimulus(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                                 input logic cond, input logic jump, input logic tk,
                                 input logic [31:0] tgt, input logic mis);
        exp_t        e;
        logic [32:0] p0, p1, p2;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_is_cond    = cond;
        upd_is_jump    = jump;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_ghr        = m_ghr;
        upd_mispredict = mis;
        p0 = modelPredict(0, pc);
        p1 = modelPredict(1, pc);
        p2 = modelPredict(2, pc);
        e.taken = {p2[32], p1[32], p0[32]};
        e.next  = {p2[31:0], p1[31:0], p0[31:0]};
        e.ghr   = m_ghr;
        e.cf    = m_cf;
        e.mis   = m_mis;
        q.push_back(e);
        g_pred = p2[32];
        @(negedge clk);
        sampleOutputs();
        if (reset) modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] upc, input logic cond, input logic jump,
                         input logic tk, input logic [31:0] tgt, input logic mis);
        applyStimulus(32'h100, 1'b1, upc, cond, jump, tk, tgt, mis);
    endtask

    initial begin
        logic pat;
        reset = 1'b0;
        modelReset();
        applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        lookup(32'h100);
        reset = 1'b1;
        lookup(32'h100);

        // Bimodal: one taken update flips the weakly-not-taken entry
        train(32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
        lookup(32'h40);
        train(32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1);
        train(32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0);
        lookup(32'h40);
        repeat (5) train(32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        train(32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1);
        lookup(32'h40);

        train(32'h200, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
        lookup(32'h200);
        train(32'h280, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
        lookup(32'h280);
        train(32'h200, 1'b1, 1'b0, 1'b0, 32'h999, 1'b0);
        lookup(32'h200);
        lookup(32'hC0);
        lookup(32'hFFFF_FFFC);

        applyStimulus(32'h1000, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b1);
        lookup(32'h1000);

        reset = 1'b0;
        modelReset();
        lookup(32'h40);
        reset = 1'b1;

        // Gshare: alternating outcomes settle into two history-selected entries
        for (int k = 0; k < 20; k++) begin
            pat = (k % 2 == 0);
            lookup(32'h40);
            if (k >= 8) checkOutput($sformatf("gsh.learn%0d", k), obs_g_taken, pat);
            train(32'h40, 1'b1, 1'b0, pat, 32'h80, g_pred != pat);
        end
        lookup(32'h40);

        reset = 1'b0;
        modelReset();
        lookup(32'h40);
        lookup(32'h200);
        reset = 1'b1;
        lookup(32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
